db_arbiter: RTL and testbench
=============================

Name: db_arbiter

Overview:
- Round-robin arbiter that shares one DATA_BUS slave port, such as a peripheral register interface, between N_MASTERS bus masters (e.g. CPU data port and DMA/CAN engine).
- Forwards the winning request combinationally to the slave.
- Records the granted master index in an outstanding-transaction FIFO and routes each response (rvalid/rdata/err) back to its originator in order.

Parameters:
N_MASTERS, 2, number of requesting masters (>=2)
MAX_OUT, 2, max granted-but-unanswered transactions (FIFO depth, >=1)
IDX_W, $clog2(N_MASTERS), width of master index (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
m_req  in  N_MASTERS  per-master request
m_we  in  N_MASTERS  per-master write enable
m_be  in  N_MASTERS x 4  per-master byte enables
m_addr  in  N_MASTERS x 32  per-master address
m_wdata  in  N_MASTERS x 32  per-master write data
m_gnt  out  N_MASTERS  per-master grant
m_rvalid  out  N_MASTERS  per-master response valid
m_rdata  out  N_MASTERS x 32  per-master read data
m_err  out  N_MASTERS  per-master error
s_req  out  1  slave request
s_we  out  1  slave write enable
s_be  out  4  slave byte enables
s_addr  out  32  slave address
s_wdata  out  32  slave write data
s_gnt  in  1  slave grant (same cycle as s_req)
s_rvalid  in  1  slave response valid (>=1 cycle after grant, in order)
s_rdata  in  32  slave read data
s_err  in  1  slave error
protocol_err_o  out  1  sticky: s_rvalid received with no outstanding transaction

Behaviour:
- Clocking and reset: one clock clk; synchronous active-low reset rst_n, sampled on posedge clk.
- State: rr_ptr (IDX_W bits), FIFO of MAX_OUT entries of IDX_W bits, count (0..MAX_OUT), protocol_err_o.
- Reset (rst_n=0 at posedge): rr_ptr=0, count=0, FIFO pointers=0, protocol_err_o=0.
  - Any in-flight transaction is abandoned; a late s_rvalid afterwards counts as stray.
  - Combinational outputs are 0 after reset while all m_req=0 and s_rvalid=0.
- Arbitration (combinational):
  - winner w = first index i with m_req[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_MASTERS.
  - full = (count==MAX_OUT).
  - s_req = |m_req & ~full.
  - s_we/s_be/s_addr/s_wdata = signals of w; these are 0 when no m_req is set.
  - m_gnt[w] = s_req & s_gnt; all other m_gnt = 0.
  - No combinational path from s_rvalid to s_req.
- Grant update (posedge, push = s_req & s_gnt):
  - Push w into the FIFO.
  - rr_ptr <= (w+1) mod N_MASTERS.
  - rr_ptr is unchanged when there is no push.
- Response routing (combinational, pop = s_rvalid & (count!=0)):
  - h = FIFO head.
  - m_rvalid[h] = pop; m_err[h] = pop & s_err.
  - m_rdata[i] = s_rdata for all i (qualified by m_rvalid).
  - All other m_rvalid/m_err = 0.
- Count update:
  - push only: +1; pop only: -1; push and pop together: count unchanged, FIFO rd/wr pointers both advance.
  - Pointers wrap modulo MAX_OUT.
- Full: s_req held 0, m_gnt all 0, requests wait. A pop in that cycle frees a slot; s_req may assert the next cycle (one-cycle bubble).
- Stray response: s_rvalid=1 with count=0 gives no m_rvalid and sets protocol_err_o=1. It stays set until reset.
- Fairness: a continuously requesting master is granted within N_MASTERS grants. The winner may change while ungranted; masters hold request signals until gnt, per the DATA_BUS protocol.
- Writes also receive an rvalid and consume a FIFO entry.
- Latency: 0 cycles request→slave; 0 cycles s_rvalid→m_rvalid.

Test Plan:
- Single read: m_req[0]=1, we=0, addr=0x4; slave gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF → m_gnt[0]=1 in cycle 0; m_rvalid[0]=1 and m_rdata=0xDEADBEEF in cycle 1; m_gnt[1]=m_rvalid[1]=0 throughout.
- Contention: m_req[0]=m_req[1]=1 held, s_gnt=1, slave rvalid one cycle after each grant → grants 0,1,0,1 on consecutive cycles; rvalids routed 0,1,0,1 one cycle later; count never exceeds 1.
- Backpressure: MAX_OUT=2, s_gnt=1, s_rvalid held 0 → two grants, then s_req=0 with count=2; pulse s_rvalid → m_rvalid to first granted master; s_req=1 the following cycle.
- Byte-enable write: m_req[1]=1, we=1, be=4'b0011, wdata=0x1234_5678 → s_be=0011, s_wdata=0x12345678, m_gnt[1]=1; s_err=1 on the response → m_err[1]=1, m_err[0]=0.
- Stray response: count=0, s_rvalid=1 → all m_rvalid=0; protocol_err_o=1 from the next cycle, still 1 ten cycles later.
- Reset mid-flight: count=1, rst_n=0 for one cycle → count=0, rr_ptr=0, protocol_err_o=0; a later s_rvalid sets protocol_err_o=1 and yields no m_rvalid.

Source files
------------

// File: rtl/db_arbiter.sv
// Round-robin arbiter sharing one DATA_BUS slave between N_MASTERS masters.
// Responses are routed back in order through a FIFO of granted master indices.
module db_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int MAX_OUT   = 2,
  localparam int IDX_W    = $clog2(N_MASTERS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_MASTERS-1:0]            m_req,
  input  logic [N_MASTERS-1:0]            m_we,
  input  logic [N_MASTERS-1:0][3:0]       m_be,
  input  logic [N_MASTERS-1:0][31:0]      m_addr,
  input  logic [N_MASTERS-1:0][31:0]      m_wdata,
  output logic [N_MASTERS-1:0]            m_gnt,
  output logic [N_MASTERS-1:0]            m_rvalid,
  output logic [N_MASTERS-1:0][31:0]      m_rdata,
  output logic [N_MASTERS-1:0]            m_err,
  output logic                            s_req,
  output logic                            s_we,
  output logic [3:0]                      s_be,
  output logic [31:0]                     s_addr,
  output logic [31:0]                     s_wdata,
  input  logic                            s_gnt,
  input  logic                            s_rvalid,
  input  logic [31:0]                     s_rdata,
  input  logic                            s_err,
  output logic                            protocol_err_o
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  bus_req_t         mreq [N_MASTERS];
  bus_req_t         sreq_bus;
  logic [IDX_W-1:0] rr_ptr, win, head;
  logic             any_req, full, push, pop;
  logic [IDX_W-1:0] fifo [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (int'(rr_ptr) + k) % N_MASTERS;
      if (!found && m_req[IDX_W'(idx)]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_req  = |m_req;
  assign full     = (count == CNT_W'(MAX_OUT));
  assign s_req    = any_req & ~full;
  assign push     = s_req & s_gnt;
  assign pop      = s_rvalid & (count != '0);
  assign head     = fifo[rd_ptr];
  assign sreq_bus = any_req ? mreq[win] : '0;
  assign {s_we, s_be, s_addr, s_wdata} = sreq_bus;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
    assign mreq[i]     = '{we: m_we[i], be: m_be[i], addr: m_addr[i], wdata: m_wdata[i]};
    assign m_gnt[i]    = push & (win == IDX_W'(i));
    assign m_rvalid[i] = pop & (head == IDX_W'(i));
    assign m_err[i]    = pop & s_err & (head == IDX_W'(i));
    assign m_rdata[i]  = s_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (win == IDX_W'(N_MASTERS - 1)) ? '0 : win + IDX_W'(1);
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // A response with nothing outstanding is a slave protocol violation.
      if (s_rvalid && count == '0) protocol_err_o <= 1'b1;
    end
  end

  // Payload needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= win;
  end

endmodule

// File: tb/tb_db_arbiter.sv
// Directed bench for db_arbiter: per-cycle vector table plus reset/stray sequences.
module tb_db_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [1:0][3:0]  m_be;
  logic [1:0][31:0] m_addr, m_wdata, m_rdata;
  logic             s_req, s_we, s_gnt, s_rvalid, s_err, protocol_err_o;
  logic [3:0]       s_be;
  logic [31:0]      s_addr, s_wdata, s_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  db_arbiter #(.N_MASTERS(2), .MAX_OUT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    bit [1:0]   req, we;
    bit [3:0]   be1;
    bit [31:0]  wd1;
    bit         sg, rv;
    bit [31:0]  rd;
    bit         se;
    bit [1:0]   egnt, erv, eerr;
    bit         esreq, ewe;
    bit [3:0]   ebe;
    bit [31:0]  eaddr, ewd;
    bit         eperr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, bit [1:0] req, bit [1:0] we, bit [3:0] be1,
      bit [31:0] wd1, bit sg, bit rv, bit [31:0] rd, bit se, bit [1:0] egnt,
      bit [1:0] erv, bit [1:0] eerr, bit esreq, bit ewe, bit [3:0] ebe,
      bit [31:0] eaddr, bit [31:0] ewd, bit eperr);
    vec_t v;
    v = '{nm, req, we, be1, wd1, sg, rv, rd, se, egnt, erv, eerr, esreq, ewe, ebe, eaddr, ewd, eperr};
    return v;
  endfunction

  // Master 0: addr 0x4, be 0xF, wdata 0; master 1: addr 0x8, be/wdata per vector.
  task automatic drive(input bit [1:0] req, input bit [1:0] we, input bit [3:0] be1,
      input bit [31:0] wd1, input bit sg, input bit rv, input bit [31:0] rd, input bit se);
    m_req = req; m_we = we;
    m_be = {be1, 4'hF}; m_addr = {32'h8, 32'h4}; m_wdata = {wd1, 32'h0};
    s_gnt = sg; s_rvalid = rv; s_rdata = rd; s_err = se;
  endtask

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [159:0] snap();
    return {19'd0, m_gnt, m_rvalid, m_err, s_req, s_we, s_be, s_addr, s_wdata,
            protocol_err_o, m_rdata[1], m_rdata[0]};
  endfunction

  task automatic idle();
    drive(2'b00, 2'b00, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    //             name         req    we     be1   wd1           sg rv rd            se  gnt    rv     err    sq we be    addr   wdata         perr
    tbl.push_back(mk("idle",      2'b00, 2'b00, 4'hF, 32'h0,        0, 0, 32'h0,        0, 2'b00, 2'b00, 2'b00, 0, 0, 4'h0, 32'h0, 32'h0,        0));
    tbl.push_back(mk("rd_req",    2'b01, 2'b00, 4'hF, 32'h0,        1, 0, 32'h0,        0, 2'b01, 2'b00, 2'b00, 1, 0, 4'hF, 32'h4, 32'h0,        0));
    tbl.push_back(mk("rd_resp",   2'b00, 2'b00, 4'hF, 32'h0,        0, 1, 32'hDEADBEEF, 0, 2'b00, 2'b01, 2'b00, 0, 0, 4'h0, 32'h0, 32'h0,        0));
    tbl.push_back(mk("ct_a",      2'b11, 2'b00, 4'hF, 32'h11111111, 1, 0, 32'h0,        0, 2'b10, 2'b00, 2'b00, 1, 0, 4'hF, 32'h8, 32'h11111111, 0));
    tbl.push_back(mk("ct_b",      2'b11, 2'b00, 4'hF, 32'h11111111, 1, 1, 32'h1,        0, 2'b01, 2'b10, 2'b00, 1, 0, 4'hF, 32'h4, 32'h0,        0));
    tbl.push_back(mk("ct_c",      2'b11, 2'b00, 4'hF, 32'h11111111, 1, 1, 32'h2,        0, 2'b10, 2'b01, 2'b00, 1, 0, 4'hF, 32'h8, 32'h11111111, 0));
    tbl.push_back(mk("ct_drain",  2'b00, 2'b00, 4'hF, 32'h0,        0, 1, 32'h3,        0, 2'b00, 2'b10, 2'b00, 0, 0, 4'h0, 32'h0, 32'h0,        0));
    tbl.push_back(mk("bp_g0",     2'b01, 2'b00, 4'hF, 32'h0,        1, 0, 32'h0,        0, 2'b01, 2'b00, 2'b00, 1, 0, 4'hF, 32'h4, 32'h0,        0));
    tbl.push_back(mk("bp_g1",     2'b10, 2'b00, 4'hF, 32'h22222222, 1, 0, 32'h0,        0, 2'b10, 2'b00, 2'b00, 1, 0, 4'hF, 32'h8, 32'h22222222, 0));
    tbl.push_back(mk("bp_full",   2'b11, 2'b00, 4'hF, 32'h22222222, 1, 0, 32'h0,        0, 2'b00, 2'b00, 2'b00, 0, 0, 4'hF, 32'h4, 32'h0,        0));
    tbl.push_back(mk("bp_pop",    2'b11, 2'b00, 4'hF, 32'h22222222, 1, 1, 32'h55,       0, 2'b00, 2'b01, 2'b00, 0, 0, 4'hF, 32'h4, 32'h0,        0));
    tbl.push_back(mk("bp_resume", 2'b11, 2'b00, 4'hF, 32'h22222222, 1, 0, 32'h0,        0, 2'b01, 2'b00, 2'b00, 1, 0, 4'hF, 32'h4, 32'h0,        0));
    tbl.push_back(mk("bp_d1",     2'b00, 2'b00, 4'hF, 32'h0,        0, 1, 32'h6,        0, 2'b00, 2'b10, 2'b00, 0, 0, 4'h0, 32'h0, 32'h0,        0));
    tbl.push_back(mk("bp_d2",     2'b00, 2'b00, 4'hF, 32'h0,        0, 1, 32'h7,        0, 2'b00, 2'b01, 2'b00, 0, 0, 4'h0, 32'h0, 32'h0,        0));
    tbl.push_back(mk("be_wr",     2'b10, 2'b10, 4'h3, 32'h12345678, 1, 0, 32'h0,        0, 2'b10, 2'b00, 2'b00, 1, 1, 4'h3, 32'h8, 32'h12345678, 0));
    tbl.push_back(mk("be_err",    2'b00, 2'b00, 4'hF, 32'h0,        0, 1, 32'h0,        1, 2'b00, 2'b10, 2'b10, 0, 0, 4'h0, 32'h0, 32'h0,        0));
    tbl.push_back(mk("stray",     2'b00, 2'b00, 4'hF, 32'h0,        0, 1, 32'h77,       1, 2'b00, 2'b00, 2'b00, 0, 0, 4'h0, 32'h0, 32'h0,        0));
    tbl.push_back(mk("stray_p1",  2'b00, 2'b00, 4'hF, 32'h0,        0, 0, 32'h0,        0, 2'b00, 2'b00, 2'b00, 0, 0, 4'h0, 32'h0, 32'h0,        1));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].we, tbl[i].be1, tbl[i].wd1, tbl[i].sg, tbl[i].rv, tbl[i].rd, tbl[i].se);
      #2;
      check(tbl[i].nm, snap(),
            {19'd0, tbl[i].egnt, tbl[i].erv, tbl[i].eerr, tbl[i].esreq, tbl[i].ewe, tbl[i].ebe,
             tbl[i].eaddr, tbl[i].ewd, tbl[i].eperr, tbl[i].rd, tbl[i].rd});
    end

    // Sticky error survives ten idle cycles.
    @(negedge clk); idle();
    repeat (10) @(negedge clk);
    #2 check("perr_sticky", 160'(protocol_err_o), 160'd1);

    // Grant master 0 (rr_ptr -> 1, one outstanding), then reset mid-flight.
    @(negedge clk);
    drive(2'b01, 2'b00, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #2 check("mf_gnt", 160'(m_gnt), 160'd1);
    @(negedge clk); idle(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    // rr_ptr back at 0: master 0 wins a tie; no grant from the slave yet.
    drive(2'b11, 2'b00, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2 check("rst_perr", 160'(protocol_err_o), 160'd0);
    check("rst_rr", 160'({s_req, m_gnt, s_addr}), 160'({1'b1, 2'b00, 32'h4}));
    // Abandoned transaction's late response is stray.
    @(negedge clk);
    drive(2'b00, 2'b00, 4'hF, 32'h0, 1'b0, 1'b1, 32'h99, 1'b0);
    #2 check("late_rv", 160'(m_rvalid), 160'd0);
    @(negedge clk); idle();
    #2 check("late_perr", 160'(protocol_err_o), 160'd1);
    // Count restarted at 0: exactly two grants fit before full.
    @(negedge clk);
    drive(2'b01, 2'b00, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #2 check("fill_1", 160'({s_req, m_gnt}), 160'({1'b1, 2'b01}));
    @(negedge clk);
    drive(2'b10, 2'b00, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #2 check("fill_2", 160'({s_req, m_gnt}), 160'({1'b1, 2'b10}));
    @(negedge clk);
    drive(2'b11, 2'b00, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #2 check("fill_full", 160'({s_req, m_gnt}), 160'({1'b0, 2'b00}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
